// File: rtl/id_operand_stage_pkg.sv
// Shared constants and FSM encoding for the ID operand stage.
package id_operand_stage_pkg;

  localparam logic [31:0] ZeroWord    = 32'h0000_0000;
  localparam logic [4:0]  NOPRegAddr  = 5'b00000;
  localparam logic [7:0]  EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [2:0]  EXE_RES_NOP = 3'b000;

  typedef enum logic {
    OPS_RUN  = 1'b0,
    OPS_WAIT = 1'b1
  } ops_state_t;

endpackage

// File: rtl/id_operand_stage_if.sv
// Decoder/forwarding inputs and ID/EX register outputs of the operand stage.
// master = surrounding pipeline, slave = id_operand_stage.
interface id_operand_stage_if #(
  parameter int DW   = 32,
  parameter int RAW  = 5,
  parameter int NFWD = 2,
  parameter int OPW  = 8,
  parameter int SELW = 3
) ();
  logic                  in_valid;
  logic                  rs_read, rt_read;
  logic [RAW-1:0]        rs_addr, rt_addr;
  logic [DW-1:0]         rs_data, rt_data;
  logic [DW-1:0]         imm;
  logic [OPW-1:0]        aluop;
  logic [SELW-1:0]       alusel;
  logic [RAW-1:0]        wd;
  logic                  wreg;
  logic [NFWD-1:0]       fwd_wreg;
  logic [NFWD*RAW-1:0]   fwd_wd;
  logic [NFWD*DW-1:0]    fwd_wdata;
  logic [NFWD-1:0]       fwd_ready;
  logic                  ex_valid;
  logic [OPW-1:0]        ex_aluop;
  logic [SELW-1:0]       ex_alusel;
  logic [DW-1:0]         ex_reg1, ex_reg2;
  logic [RAW-1:0]        ex_wd;
  logic                  ex_wreg;

  modport master (
    output in_valid, rs_read, rt_read, rs_addr, rt_addr, rs_data, rt_data, imm,
           aluop, alusel, wd, wreg, fwd_wreg, fwd_wd, fwd_wdata, fwd_ready,
    input  ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg
  );

  modport slave (
    input  in_valid, rs_read, rt_read, rs_addr, rt_addr, rs_data, rt_data, imm,
           aluop, alusel, wd, wreg, fwd_wreg, fwd_wd, fwd_wdata, fwd_ready,
    output ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg
  );
endinterface

// File: rtl/id_operand_stage_operand_bypass_mux.sv
// Resolves one operand: immediate, r0, youngest matching forward source or
// regfile. pending flags a matching source whose result is not ready yet.
module operand_bypass_mux
  import id_operand_stage_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RAW  = 5,
  parameter int NFWD = 2
) (
  input  logic                read,
  input  logic [RAW-1:0]      addr,
  input  logic [DW-1:0]       rdata,
  input  logic [DW-1:0]       imm,
  input  logic [NFWD-1:0]     fwd_wreg,
  input  logic [NFWD*RAW-1:0] fwd_wd,
  input  logic [NFWD*DW-1:0]  fwd_wdata,
  input  logic [NFWD-1:0]     fwd_ready,
  output logic [DW-1:0]       val,
  output logic                pending
);

  // Walk oldest to youngest so the lowest matching index overwrites last.
  always_comb begin
    val     = rdata;
    pending = 1'b0;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (fwd_wreg[i] && (fwd_wd[i*RAW +: RAW] == addr)) begin
        val     = fwd_wdata[i*DW +: DW];
        pending = ~fwd_ready[i];
      end
    end
    if (!read) begin
      val     = imm;
      pending = 1'b0;
    end else if (addr == RAW'(NOPRegAddr)) begin
      val     = DW'(ZeroWord);
      pending = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// Operand resolution + ID/EX register with load-use interlock and a sticky
// interlock timeout. Optional stall counter under OPSTAGE_STALL_CNT_EN.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int DW       = 32,
  parameter int RAW      = 5,
  parameter int NFWD     = 2,
  parameter int OPW      = 8,
  parameter int SELW     = 3,
  parameter int MAX_WAIT = 31
) (
  input  logic               clk,
  input  logic               rst,
  id_operand_stage_if.slave  bus,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic               stall_req,
`ifdef OPSTAGE_STALL_CNT_EN
  input  logic               stall_cnt_clr,
  output logic [31:0]        stall_cnt,
`endif
  output logic               err_timeout
);

  localparam int WCW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic            valid;
    logic [OPW-1:0]  aluop;
    logic [SELW-1:0] alusel;
    logic [DW-1:0]   reg1;
    logic [DW-1:0]   reg2;
    logic [RAW-1:0]  wd;
    logic            wreg;
  } ex_t;

  localparam ex_t EX_BUBBLE = '{
    valid: 1'b0, aluop: OPW'(EXE_NOP_OP), alusel: SELW'(EXE_RES_NOP),
    reg1: DW'(ZeroWord), reg2: DW'(ZeroWord), wd: RAW'(NOPRegAddr), wreg: 1'b0
  };

  logic [DW-1:0]  op1, op2;
  logic           pend1, pend2, hazard;
  ex_t            ex_q;
  ops_state_t     state, state_nxt;
  logic           wait_clr, wait_inc;
  logic [WCW-1:0] wait_cnt;

  operand_bypass_mux #(.DW(DW), .RAW(RAW), .NFWD(NFWD)) u_mux_rs (
    .read(bus.rs_read), .addr(bus.rs_addr), .rdata(bus.rs_data), .imm(bus.imm),
    .fwd_wreg(bus.fwd_wreg), .fwd_wd(bus.fwd_wd), .fwd_wdata(bus.fwd_wdata),
    .fwd_ready(bus.fwd_ready), .val(op1), .pending(pend1)
  );

  operand_bypass_mux #(.DW(DW), .RAW(RAW), .NFWD(NFWD)) u_mux_rt (
    .read(bus.rt_read), .addr(bus.rt_addr), .rdata(bus.rt_data), .imm(bus.imm),
    .fwd_wreg(bus.fwd_wreg), .fwd_wd(bus.fwd_wd), .fwd_wdata(bus.fwd_wdata),
    .fwd_ready(bus.fwd_ready), .val(op2), .pending(pend2)
  );

  assign hazard    = bus.in_valid & (pend1 | pend2);
  assign stall_req = hazard | stall_i;

  // ID/EX register: flush, then hold on stall, then bubble on hazard, else load.
  always_ff @(posedge clk) begin
    if (rst || flush_i || (!stall_i && hazard)) begin
      ex_q <= EX_BUBBLE;
    end else if (!stall_i) begin
      ex_q.valid  <= bus.in_valid;
      ex_q.aluop  <= bus.aluop;
      ex_q.alusel <= bus.alusel;
      ex_q.reg1   <= op1;
      ex_q.reg2   <= op2;
      ex_q.wd     <= bus.wd;
      ex_q.wreg   <= bus.wreg & bus.in_valid;
    end
  end

  assign bus.ex_valid  = ex_q.valid;
  assign bus.ex_aluop  = ex_q.aluop;
  assign bus.ex_alusel = ex_q.alusel;
  assign bus.ex_reg1   = ex_q.reg1;
  assign bus.ex_reg2   = ex_q.reg2;
  assign bus.ex_wd     = ex_q.wd;
  assign bus.ex_wreg   = ex_q.wreg;

  // Interlock FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= OPS_RUN;
    else     state <= state_nxt;
  end

  // Enter WAIT on an unmasked hazard, leave when it clears or on flush.
  always_comb begin
    state_nxt = state;
    case (state)
      OPS_RUN:  if (hazard && !flush_i && !stall_i) state_nxt = OPS_WAIT;
      OPS_WAIT: if (!hazard || flush_i)             state_nxt = OPS_RUN;
      default:                                      state_nxt = OPS_RUN;
    endcase
  end

  // Wait counter controls: held at zero in RUN, counts live hazard cycles in WAIT.
  always_comb begin
    wait_clr = (state == OPS_RUN);
    wait_inc = (state == OPS_WAIT) && hazard && !stall_i && !flush_i &&
               (wait_cnt != WCW'(MAX_WAIT));
  end

  // Saturating wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (wait_clr)      wait_cnt <= '0;
      else if (wait_inc) wait_cnt <= wait_cnt + 1'b1;
      if (wait_inc && (wait_cnt == WCW'(MAX_WAIT - 1))) err_timeout <= 1'b1;
    end
  end

`ifdef OPSTAGE_STALL_CNT_EN
  // Free-running count of interlock bubbles; clear beats increment.
  always_ff @(posedge clk) begin
    if (rst || stall_cnt_clr)    stall_cnt <= '0;
    else if (hazard && !stall_i) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios plus a
// randomized run against a behavioural operand/EX model.
module tb_id_operand_stage;
  localparam int DW = 32, RAW = 5, NFWD = 2, OPW = 8, SELW = 3, MAX_WAIT = 31;

  logic clk = 1'b0;
  logic rst, stall_i, flush_i;
  logic stall_req, err_timeout;
`ifdef OPSTAGE_STALL_CNT_EN
  logic        stall_cnt_clr;
  logic [31:0] stall_cnt;
`endif

  id_operand_stage_if #(.DW(DW), .RAW(RAW), .NFWD(NFWD), .OPW(OPW), .SELW(SELW)) bus ();

  id_operand_stage #(.DW(DW), .RAW(RAW), .NFWD(NFWD), .OPW(OPW), .SELW(SELW),
                     .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .stall_i(stall_i), .flush_i(flush_i),
    .stall_req(stall_req),
`ifdef OPSTAGE_STALL_CNT_EN
    .stall_cnt_clr(stall_cnt_clr), .stall_cnt(stall_cnt),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model of the EX register contents.
  logic            m_valid, m_wreg;
  logic [OPW-1:0]  m_aluop;
  logic [SELW-1:0] m_alusel;
  logic [DW-1:0]   m_reg1, m_reg2;
  logic [RAW-1:0]  m_wd;

  // Operand rule: imm if not read, 0 for r0, else first (youngest) match, else regfile.
  function automatic void resolve(input logic rd, input logic [RAW-1:0] a,
                                  input logic [DW-1:0] rf,
                                  output logic [DW-1:0] v, output logic p);
    v = rf; p = 1'b0;
    if (!rd) begin v = bus.imm; return; end
    if (a == '0) begin v = '0; return; end
    for (int i = 0; i < NFWD; i++) begin
      if (bus.fwd_wreg[i] && bus.fwd_wd[i*RAW +: RAW] == a) begin
        v = bus.fwd_wdata[i*DW +: DW];
        p = !bus.fwd_ready[i];
        return;
      end
    end
  endfunction

  function automatic logic model_hazard();
    logic [DW-1:0] v1, v2; logic p1, p2;
    resolve(bus.rs_read, bus.rs_addr, bus.rs_data, v1, p1);
    resolve(bus.rt_read, bus.rt_addr, bus.rt_data, v2, p2);
    return bus.in_valid && (p1 || p2);
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_wreg = 0; m_aluop = '0; m_alusel = '0;
    m_reg1 = '0; m_reg2 = '0; m_wd = '0;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    logic [DW-1:0] v1, v2; logic p1, p2;
    resolve(bus.rs_read, bus.rs_addr, bus.rs_data, v1, p1);
    resolve(bus.rt_read, bus.rt_addr, bus.rt_data, v2, p2);
    if (flush_i || (!stall_i && bus.in_valid && (p1 || p2))) model_bubble();
    else if (!stall_i) begin
      m_valid = bus.in_valid; m_wreg = bus.wreg && bus.in_valid;
      m_aluop = bus.aluop; m_alusel = bus.alusel;
      m_reg1 = v1; m_reg2 = v2; m_wd = bus.wd;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    bus.in_valid = 0; bus.rs_read = 0; bus.rt_read = 0;
    bus.rs_addr = '0; bus.rt_addr = '0; bus.rs_data = '0; bus.rt_data = '0;
    bus.imm = '0; bus.aluop = '0; bus.alusel = '0; bus.wd = '0; bus.wreg = 0;
    bus.fwd_wreg = '0; bus.fwd_wd = '0; bus.fwd_wdata = '0; bus.fwd_ready = '1;
    stall_i = 0; flush_i = 0;
`ifdef OPSTAGE_STALL_CNT_EN
    stall_cnt_clr = 0;
`endif
  endtask

  task automatic do_reset();
    rst = 1; @(posedge clk); #1; rst = 0;
    model_bubble();
  endtask

  task automatic test_reset();
    idle();
    bus.in_valid = 1; bus.aluop = 8'h5A; bus.alusel = 3'h5; bus.wreg = 1; bus.wd = 5'd9;
    do_reset(); idle(); #1;
    n_assert++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0b want 0", bus.ex_valid); end
    n_assert++; if (bus.ex_wreg !== 1'b0) begin n_fail++; $display("FAIL reset_wreg got %0b want 0", bus.ex_wreg); end
    n_assert++; if (bus.ex_aluop !== 8'h00 || bus.ex_alusel !== 3'h0) begin n_fail++; $display("FAIL reset_ops got %h/%h want 00/0", bus.ex_aluop, bus.ex_alusel); end
    n_assert++; if (bus.ex_reg1 !== 32'h0 || bus.ex_wd !== 5'd0) begin n_fail++; $display("FAIL reset_data got %h/%0d want 0/0", bus.ex_reg1, bus.ex_wd); end
    n_assert++; if (stall_req !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_flags got %0b/%0b want 0/0", stall_req, err_timeout); end
  endtask

  task automatic test_fwd_priority();
    do_reset(); idle();
    bus.in_valid = 1; bus.rs_read = 1; bus.rs_addr = 5'd3; bus.rs_data = 32'hDEAD;
    bus.fwd_wreg = 2'b11; bus.fwd_wd = {5'd3, 5'd3}; bus.fwd_wdata = {32'hBBBB, 32'hAAAA};
    bus.fwd_ready = 2'b11; #1;
    n_assert++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL fwd_prio_stall got %0b want 0", stall_req); end
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'hAAAA || bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_prio_reg1 got %h v%0b want 0000aaaa v1", bus.ex_reg1, bus.ex_valid); end
    // Youngest not ready must stall even though the older copy is ready.
    bus.fwd_ready = 2'b10; #1;
    n_assert++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL fwd_young_pending got %0b want 1", stall_req); end
    tick();
    n_assert++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL fwd_young_bubble got %0b want 0", bus.ex_valid); end
  endtask

  task automatic test_zero_imm();
    do_reset(); idle();
    bus.in_valid = 1; bus.rs_read = 1; bus.rs_addr = 5'd0; bus.rs_data = 32'h9999;
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd0}; bus.fwd_wdata = {32'h0, 32'h1234};
    bus.rt_read = 0; bus.imm = 32'h00FF;
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'h0) begin n_fail++; $display("FAIL zero_reg1 got %h want 0", bus.ex_reg1); end
    n_assert++; if (bus.ex_reg2 !== 32'h00FF) begin n_fail++; $display("FAIL imm_reg2 got %h want 000000ff", bus.ex_reg2); end
    // Same register on both ports resolves identically from the older source.
    bus.rs_addr = 5'd7; bus.rt_addr = 5'd7; bus.rt_read = 1;
    bus.fwd_wreg = 2'b10; bus.fwd_wd = {5'd7, 5'd7}; bus.fwd_wdata = {32'hC0DE, 32'h1111};
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'hC0DE || bus.ex_reg2 !== 32'hC0DE) begin n_fail++; $display("FAIL same_addr got %h/%h want c0de/c0de", bus.ex_reg1, bus.ex_reg2); end
  endtask

  task automatic test_load_interlock();
    do_reset(); idle();
    bus.in_valid = 1; bus.rs_read = 1; bus.rs_addr = 5'd5; bus.aluop = 8'h21; bus.wreg = 1; bus.wd = 5'd6;
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd5}; bus.fwd_ready = 2'b10;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_assert++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL interlock_stall%0d got %0b want 1", c, stall_req); end
      tick();
      n_assert++; if (bus.ex_valid !== 1'b0 || bus.ex_wreg !== 1'b0) begin n_fail++; $display("FAIL interlock_bubble%0d got v%0b w%0b want 0/0", c, bus.ex_valid, bus.ex_wreg); end
    end
    bus.fwd_ready = 2'b11; bus.fwd_wdata = {32'h0, 32'h77}; #1;
    n_assert++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL interlock_release got %0b want 0", stall_req); end
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'h77 || bus.ex_valid !== 1'b1 || bus.ex_wreg !== 1'b1) begin n_fail++; $display("FAIL interlock_result got %h v%0b w%0b want 77 v1 w1", bus.ex_reg1, bus.ex_valid, bus.ex_wreg); end
  endtask

  task automatic test_timeout();
    do_reset(); idle();
    bus.in_valid = 1; bus.rs_read = 1; bus.rs_addr = 5'd5;
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd5}; bus.fwd_ready = 2'b10;
    repeat (20) tick();
    n_assert++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %0b want 0", err_timeout); end
    repeat (20) tick();
    n_assert++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_set got %0b want 1", err_timeout); end
    bus.fwd_ready = 2'b11;
    repeat (3) tick();
    n_assert++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got %0b want 1", err_timeout); end
    do_reset(); #1;
    n_assert++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_rst got %0b want 0", err_timeout); end
  endtask

  task automatic test_stall_flush();
    do_reset(); idle();
    bus.in_valid = 1; bus.imm = 32'h55; bus.aluop = 8'h21; bus.alusel = 3'h1; bus.wd = 5'd7; bus.wreg = 1;
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'h55 || bus.ex_wd !== 5'd7 || bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL sf_load got %h/%0d/%0b want 55/7/1", bus.ex_reg1, bus.ex_wd, bus.ex_valid); end
    bus.imm = 32'h66; bus.aluop = 8'h22; bus.wd = 5'd8; stall_i = 1; #1;
    n_assert++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL sf_stall_req got %0b want 1", stall_req); end
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'h55 || bus.ex_aluop !== 8'h21 || bus.ex_wd !== 5'd7 || bus.ex_wreg !== 1'b1 || bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL sf_hold got %h/%h/%0d want 55/21/7", bus.ex_reg1, bus.ex_aluop, bus.ex_wd); end
    flush_i = 1;
    tick();
    n_assert++; if (bus.ex_valid !== 1'b0 || bus.ex_wreg !== 1'b0) begin n_fail++; $display("FAIL sf_flush got v%0b w%0b want 0/0", bus.ex_valid, bus.ex_wreg); end
    stall_i = 0; bus.rs_read = 1; bus.rs_addr = 5'd5;
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd5}; bus.fwd_ready = 2'b10; #1;
    n_assert++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL sf_flush_hazard_req got %0b want 1", stall_req); end
    tick();
    n_assert++; if (bus.ex_valid !== 1'b0) begin n_fail++; $display("FAIL sf_flush_hazard got %0b want 0", bus.ex_valid); end
    flush_i = 0; bus.fwd_ready = 2'b11; bus.fwd_wdata = {32'h0, 32'h9};
    tick();
    n_assert++; if (bus.ex_reg1 !== 32'h9 || bus.ex_valid !== 1'b1) begin n_fail++; $display("FAIL sf_resume got %h v%0b want 9 v1", bus.ex_reg1, bus.ex_valid); end
  endtask

  task automatic test_random();
    logic exp_sr;
    do_reset(); idle();
    for (int n = 0; n < 400; n++) begin
      bus.in_valid = ($urandom_range(0, 7) != 0);
      bus.rs_read = $urandom_range(0, 1); bus.rt_read = $urandom_range(0, 1);
      bus.rs_addr = RAW'($urandom_range(0, 3)); bus.rt_addr = RAW'($urandom_range(0, 3));
      bus.rs_data = $urandom; bus.rt_data = $urandom; bus.imm = $urandom;
      bus.aluop = OPW'($urandom); bus.alusel = SELW'($urandom);
      bus.wd = RAW'($urandom); bus.wreg = $urandom_range(0, 1);
      for (int i = 0; i < NFWD; i++) begin
        bus.fwd_wreg[i] = $urandom_range(0, 1);
        bus.fwd_wd[i*RAW +: RAW] = RAW'($urandom_range(0, 3));
        bus.fwd_wdata[i*DW +: DW] = $urandom;
        bus.fwd_ready[i] = ($urandom_range(0, 3) != 0);
      end
      stall_i = ($urandom_range(0, 7) == 0);
      flush_i = ($urandom_range(0, 15) == 0);
      #1;
      exp_sr = model_hazard() || stall_i;
      n_assert++; if (stall_req !== exp_sr) begin n_fail++; $display("FAIL rnd_stall_req[%0d] got %0b want %0b", n, stall_req, exp_sr); end
      tick();
      n_assert++;
      if (bus.ex_valid !== m_valid || bus.ex_wreg !== m_wreg || bus.ex_aluop !== m_aluop || bus.ex_alusel !== m_alusel ||
          (m_valid && (bus.ex_reg1 !== m_reg1 || bus.ex_reg2 !== m_reg2 || bus.ex_wd !== m_wd))) begin
        n_fail++;
        $display("FAIL rnd_ex[%0d] got v%0b w%0b op%h sel%h r1 %h r2 %h wd%0d want v%0b w%0b op%h sel%h r1 %h r2 %h wd%0d",
                 n, bus.ex_valid, bus.ex_wreg, bus.ex_aluop, bus.ex_alusel, bus.ex_reg1, bus.ex_reg2, bus.ex_wd,
                 m_valid, m_wreg, m_aluop, m_alusel, m_reg1, m_reg2, m_wd);
      end
    end
  endtask

`ifdef OPSTAGE_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset(); idle(); #1;
    n_assert++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL scnt_reset got %0d want 0", stall_cnt); end
    bus.in_valid = 1; bus.rs_read = 1; bus.rs_addr = 5'd4;
    bus.fwd_wreg = 2'b01; bus.fwd_wd = {5'd0, 5'd4}; bus.fwd_ready = 2'b10;
    repeat (4) tick();
    n_assert++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL scnt_four got %0d want 4", stall_cnt); end
    stall_i = 1; tick(); stall_i = 0;
    n_assert++; if (stall_cnt !== 32'd4) begin n_fail++; $display("FAIL scnt_stall_hold got %0d want 4", stall_cnt); end
    stall_cnt_clr = 1; tick(); stall_cnt_clr = 0;
    n_assert++; if (stall_cnt !== 32'd0) begin n_fail++; $display("FAIL scnt_clr got %0d want 0", stall_cnt); end
    tick();
    n_assert++; if (stall_cnt !== 32'd1) begin n_fail++; $display("FAIL scnt_after_clr got %0d want 1", stall_cnt); end
  endtask
`endif

  initial begin
    idle(); rst = 1;
    test_reset();
    test_fwd_priority();
    test_zero_imm();
    test_load_interlock();
    test_timeout();
    test_stall_flush();
    test_random();
`ifdef OPSTAGE_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Operand-resolution and ID/EX pipeline-register stage; sits between the instruction decoder and the execute stage.
- Takes decoded fields plus regfile read data and selects each operand from N parametrised forwarding sources, the regfile, or the immediate.
- Detects operands that are not yet available (load or multi-cycle result in flight) and interlocks with a bubble.
- Registers the result into EX with stall and flush control.

Parameters:
- DW, 32, data/operand width
- RAW, 5, register address width
- NFWD, 2, number of forwarding sources; index 0 = youngest (EX), higher = older (MEM, ...)
- OPW, 8, aluop width
- SELW, 3, alusel width
- MAX_WAIT, 31, interlock cycles before timeout error

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  decoded instruction present
- rs_read, rt_read  in  1 each  operand 1/2 read from regfile (else immediate)
- rs_addr, rt_addr  in  RAW each  source register addresses
- rs_data, rt_data  in  DW each  regfile read data
- imm  in  DW  decoded immediate
- aluop  in  OPW; alusel  in  SELW; wd  in  RAW; wreg  in  1  decoded control
- fwd_wreg  in  NFWD  source i writes a register
- fwd_wd  in  NFWD*RAW  source i destination, slice i at [i*RAW +: RAW]
- fwd_wdata  in  NFWD*DW  source i result
- fwd_ready  in  NFWD  source i result valid this cycle (0 = load/multicycle pending)
- stall_i  in  1  downstream hold
- flush_i  in  1  kill ID and EX contents
- stall_req  out  1  ask fetch/decoder to hold current instruction
- ex_valid  out  1; ex_aluop  out  OPW; ex_alusel  out  SELW; ex_reg1, ex_reg2  out  DW; ex_wd  out  RAW; ex_wreg  out  1
- err_timeout  out  1  sticky interlock timeout

Behaviour:
- Reset (already decided): reset rst, synchronous, active-high.
  - All ex_* outputs are 0; aluop/alusel are the NOP encodings.
  - stall_req = 0, err_timeout = 0, FSM = RUN, wait counter = 0.
- Operand select, per operand, combinational:
  - If not read, the operand is imm.
  - If read and addr == 0, the operand is 0; register 0 is never forwarded.
  - Otherwise the lowest index i with fwd_wreg[i] and fwd_wd[i] == addr wins; the operand is fwd_wdata[i].
  - If that winning source has fwd_ready[i] = 0, the operand is "pending".
  - With no match, the operand is regfile data.
- hazard = in_valid & (either operand pending).
- stall_req = hazard | stall_i.
- EX register update on each clk, in priority order:
  - flush_i: ex_valid = 0, ex_wreg = 0, NOP ops.
  - else stall_i: hold all ex_*.
  - else hazard: insert a bubble (ex_valid = 0, ex_wreg = 0, NOP).
  - else load the resolved fields; ex_valid = in_valid; ex_wreg = wreg & in_valid.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- FSM:
  - RUN -> WAIT when hazard & !flush_i & !stall_i. The counter is cleared on entry.
  - WAIT -> RUN when !hazard or flush_i.
  - WAIT: the counter increments each cycle hazard persists and saturates at MAX_WAIT.
  - When the counter reaches MAX_WAIT, err_timeout is set; it stays set until rst.
  - stall_i in WAIT freezes the counter.
- Boundaries:
  - Same address in two sources: youngest wins, even if older is ready and youngest is not, which gives a stall.
  - rs_addr == rt_addr: both operands resolve identically.
  - flush_i with hazard: flush wins; stall_req still follows hazard combinationally.
  - rst mid-WAIT: returns to RUN.

Optional Feature:
- Macro OPSTAGE_STALL_CNT_EN.
- With the macro defined:
  - Adds output stall_cnt (32 bit). It counts cycles with hazard = 1 and stall_i = 0.
  - It wraps at 2^32 and is cleared by rst.
  - Adds input stall_cnt_clr (1 bit). This is a synchronous clear that takes priority over increment.
- Without the macro, neither port exists and no counter logic is built.

Decomposition:
- Shared defines header holds:
  - ZeroWord, NOPRegAddr, EXE_NOP_OP, EXE_RES_NOP
  - FSM state encodings OPS_RUN/OPS_WAIT
- Sub-module operand_bypass_mux (parameters DW, RAW, NFWD), combinational:
  - Inputs: read, addr, regfile data, imm, fwd_*.
  - Outputs: operand value, pending.
  - Instantiated twice, once per operand.

Test Plan:
- rs = 3 read, fwd0 wd = 3 data 0xAAAA ready, fwd1 wd = 3 data 0xBBBB ready -> next cycle ex_reg1 = 0xAAAA, stall_req = 0.
- rs = 0 read, fwd0 wreg = 1 wd = 0 data 0x1234 -> ex_reg1 = 0. rt_read = 0, imm = 0x00FF -> ex_reg2 = 0x00FF.
- rs = 5, fwd0 wd = 5 ready = 0 for 2 cycles, then ready with 0x77:
  - stall_req = 1 for 2 cycles, and 2 bubbles reach EX (ex_valid = 0).
  - Then ex_reg1 = 0x77 with ex_valid = 1.
- Hazard held for MAX_WAIT = 31 cycles -> err_timeout = 1 and it remains 1 after the hazard clears. rst -> 0.
- stall_i = 1 with a valid instruction -> ex_* unchanged. Simultaneous flush_i = 1 -> ex_valid = 0, ex_wreg = 0 next cycle.
- OPSTAGE_STALL_CNT_EN: 4 hazard cycles -> stall_cnt = 4. stall_cnt_clr during a hazard -> 0 next cycle.
